// File: rtl/return_address_stack_pkg.sv
// Shared definitions for the return-address stack and its op decoder.
// Link-register constants, stack op encoding and checkpoint sizing.
package return_address_stack_pkg;

    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    typedef enum logic [1:0] {
        RAS_NONE    = 2'd0,
        RAS_PUSH    = 2'd1,
        RAS_POP     = 2'd2,
        RAS_POPPUSH = 2'd3
    } ras_op_e;

    function automatic int ckpt_width(input int depth_bit);
        return 2 * depth_bit + 1;
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

endpackage

// File: rtl/return_address_stack_ras_op_decoder.sv
// Classifies a jal/jalr as a stack push, pop or pop-then-push
// from its rd/rs1 link usage. Purely combinational.
module ras_op_decoder
    import return_address_stack_pkg::*;
(
    input  logic       is_jal,
    input  logic       is_jalr,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    output ras_op_e    op
);

    logic w_rd_link;
    logic w_rs1_link;

    assign w_rd_link  = is_link(rd);
    assign w_rs1_link = is_link(rs1);

    // Map link usage onto the stack operation
    always_comb begin
        op = RAS_NONE;
        if (is_jal) begin
            if (w_rd_link) op = RAS_PUSH;
        end else if (is_jalr) begin
            if (!w_rd_link && w_rs1_link)
                op = RAS_POP;
            else if (w_rd_link && !w_rs1_link)
                op = RAS_PUSH;
            else if (w_rd_link && w_rs1_link)
                op = (rd != rs1) ? RAS_POPPUSH : RAS_PUSH;
        end
    end

endmodule

// File: rtl/return_address_stack.sv
// Circular return-address stack predicting jalr-return targets at ID.
// Pointer state is rolled back from the EX checkpoint on a flush.
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int DEPTH_BIT = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ID_valid,
    input  logic                               ID_stall,
    input  logic                               ID_is_jal,
    input  logic                               ID_is_jalr,
    input  logic [4:0]                         ID_rd,
    input  logic [4:0]                         ID_rs1,
    input  logic [31:0]                        ID_pc,
    input  logic                               EX_flush,
    input  logic [ckpt_width(DEPTH_BIT)-1:0]   ID_EX_ras_ckpt,
    output logic                               ras_pred_valid,
    output logic [31:0]                        ras_pred_target,
    output logic [ckpt_width(DEPTH_BIT)-1:0]   ras_ckpt,
    output logic                               ras_empty,
    output logic                               ras_full
);

    localparam int N = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_BIT:0]   CNT_ONE = 1;
    localparam logic [DEPTH_BIT:0]   CNT_FULL = (DEPTH_BIT+1)'(N);

    logic [31:0]          r_entries [N];
    logic [DEPTH_BIT-1:0] r_ptr;
    logic [DEPTH_BIT:0]   r_count;

    ras_op_e              w_op_raw;
    ras_op_e              w_op;
    logic                 w_act;
    logic                 w_nonempty;
    logic [DEPTH_BIT-1:0] w_tos;
    logic [31:0]          w_pc4;
    logic [DEPTH_BIT-1:0] w_ptr_nxt;
    logic [DEPTH_BIT:0]   w_cnt_nxt;
    logic                 w_wr_en;
    logic [DEPTH_BIT-1:0] w_wr_idx;

    ras_op_decoder u_dec (
        .is_jal  (ID_is_jal),
        .is_jalr (ID_is_jalr),
        .rd      (ID_rd),
        .rs1     (ID_rs1),
        .op      (w_op_raw)
    );

    assign w_act      = ID_valid && !ID_stall && !EX_flush;
    assign w_op       = w_act ? w_op_raw : RAS_NONE;
    assign w_nonempty = (r_count != '0);
    assign w_tos      = r_ptr - PTR_ONE;
    assign w_pc4      = ID_pc + 32'd4;

    assign ras_empty       = (r_count == '0);
    assign ras_full        = (r_count == CNT_FULL);
    assign ras_pred_target = r_entries[w_tos];
    assign ras_pred_valid  = ID_valid && !EX_flush && w_nonempty &&
                             ((w_op_raw == RAS_POP) ||
                              (w_op_raw == RAS_POPPUSH));
    assign ras_ckpt        = {w_cnt_nxt, w_ptr_nxt};

    // Post-operation pointer/count and the entry write, if any
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_count;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_ptr;
        if (w_op == RAS_PUSH ||
            (w_op == RAS_POPPUSH && !w_nonempty)) begin
            w_wr_en   = 1'b1;
            w_ptr_nxt = r_ptr + PTR_ONE;
            if (!ras_full) w_cnt_nxt = r_count + CNT_ONE;
        end else if (w_op == RAS_POPPUSH) begin
            w_wr_en  = 1'b1;
            w_wr_idx = w_tos;
        end else if (w_op == RAS_POP && w_nonempty) begin
            w_ptr_nxt = w_tos;
            w_cnt_nxt = r_count - CNT_ONE;
        end
    end

    // Pointer state: flush restores the checkpoint, else apply the op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (EX_flush) begin
            {r_count, r_ptr} <= ID_EX_ras_ckpt;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_count <= w_cnt_nxt;
        end
    end

    // Entry storage; wrong-path writes are intentionally not undone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) r_entries[i] <= '0;
        end else if (w_wr_en) begin
            r_entries[w_wr_idx] <= w_pc4;
        end
    end

endmodule

// File: tb/tb_return_address_stack.sv
// Directed self-checking bench for return_address_stack.
// Hand-computed expectations for push/pop/poppush/flush/stall.
module tb_return_address_stack;

    localparam int DB = 3;
    localparam int CW = 2 * DB + 1;

    logic          clk;
    logic          reset;
    logic          ID_valid;
    logic          ID_stall;
    logic          ID_is_jal;
    logic          ID_is_jalr;
    logic [4:0]    ID_rd;
    logic [4:0]    ID_rs1;
    logic [31:0]   ID_pc;
    logic          EX_flush;
    logic [CW-1:0] ID_EX_ras_ckpt;
    logic          ras_pred_valid;
    logic [31:0]   ras_pred_target;
    logic [CW-1:0] ras_ckpt;
    logic          ras_empty;
    logic          ras_full;

    int n_checks = 0;
    int n_fail   = 0;

    return_address_stack #(.DEPTH_BIT(DB)) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_valid        (ID_valid),
        .ID_stall        (ID_stall),
        .ID_is_jal       (ID_is_jal),
        .ID_is_jalr      (ID_is_jalr),
        .ID_rd           (ID_rd),
        .ID_rs1          (ID_rs1),
        .ID_pc           (ID_pc),
        .EX_flush        (EX_flush),
        .ID_EX_ras_ckpt  (ID_EX_ras_ckpt),
        .ras_pred_valid  (ras_pred_valid),
        .ras_pred_target (ras_pred_target),
        .ras_ckpt        (ras_ckpt),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ck(input int cnt, input int ptr);
        return 32'((cnt << DB) | ptr);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic j, input logic jr,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [31:0] pc);
        ID_valid   = v;
        ID_is_jal  = j;
        ID_is_jalr = jr;
        ID_rd      = rd;
        ID_rs1     = rs1;
        ID_pc      = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
    endtask

    task automatic push(input logic [31:0] pc);
        drive(1'b1, 1'b1, 1'b0, 5'd1, 5'd0, pc);
    endtask

    task automatic ret(input logic [31:0] pc);
        drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd1, pc);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        ID_stall = 1'b0;
        EX_flush = 1'b0;
        ID_EX_ras_ckpt = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        do_reset();

        settle();
        chk("rst_valid", 32'(ras_pred_valid), 32'd0);
        chk("rst_target", ras_pred_target, 32'h0);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        chk("rst_full", 32'(ras_full), 32'd0);
        chk("rst_ckpt", 32'(ras_ckpt), 32'd0);
        step();

        // call then return
        push(32'h100);
        settle();
        chk("call_ckpt", 32'(ras_ckpt), ck(1, 1));
        chk("call_noval", 32'(ras_pred_valid), 32'd0);
        step();
        ret(32'h108);
        settle();
        chk("ret_valid", 32'(ras_pred_valid), 32'd1);
        chk("ret_target", ras_pred_target, 32'h104);
        chk("ret_ckpt", 32'(ras_ckpt), ck(0, 0));
        step();
        idle();
        settle();
        chk("ret_empty", 32'(ras_empty), 32'd1);
        step();

        // pop on empty stack
        drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd5, 32'h200);
        settle();
        chk("epop_valid", 32'(ras_pred_valid), 32'd0);
        chk("epop_ckpt", 32'(ras_ckpt), 32'd0);
        step();
        idle();
        settle();
        chk("epop_after", 32'(ras_ckpt), 32'd0);
        chk("epop_empty", 32'(ras_empty), 32'd1);
        step();

        // nine pushes wrap and overwrite the oldest
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 32'(i * 4));
            step();
        end
        idle();
        settle();
        chk("wrap_full", 32'(ras_full), 32'd1);
        chk("wrap_ckpt", 32'(ras_ckpt), ck(8, 1));
        step();
        for (int i = 0; i < 8; i++) begin
            ret(32'h1000);
            settle();
            chk("wrap_pval", 32'(ras_pred_valid), 32'd1);
            chk("wrap_ptgt", ras_pred_target, 32'(32'h24 - 4 * i));
            step();
        end
        ret(32'h1000);
        settle();
        chk("wrap_9th", 32'(ras_pred_valid), 32'd0);
        chk("wrap_end", 32'(ras_ckpt), ck(0, 1));
        step();

        // pop-then-push
        do_reset();
        push(32'h100);
        step();
        push(32'h200);
        step();
        drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 32'h300);
        settle();
        chk("pp_valid", 32'(ras_pred_valid), 32'd1);
        chk("pp_target", ras_pred_target, 32'h204);
        chk("pp_ckpt", 32'(ras_ckpt), ck(2, 2));
        step();
        ret(32'h400);
        settle();
        chk("pp_tos", ras_pred_target, 32'h304);
        step();
        ret(32'h400);
        settle();
        chk("pp_next", ras_pred_target, 32'h104);
        step();

        // flush beats a same-cycle ID push
        do_reset();
        push(32'h100);
        settle();
        chk("fl_ck1", 32'(ras_ckpt), ck(1, 1));
        step();
        push(32'h500);
        step();
        push(32'h700);
        EX_flush = 1'b1;
        ID_EX_ras_ckpt = CW'(ck(1, 1));
        settle();
        chk("fl_ckpt", 32'(ras_ckpt), ck(2, 2));
        step();
        EX_flush = 1'b0;
        idle();
        settle();
        chk("fl_rest", 32'(ras_ckpt), ck(1, 1));
        step();
        ret(32'h800);
        settle();
        chk("fl_pval", 32'(ras_pred_valid), 32'd1);
        chk("fl_ptgt", ras_pred_target, 32'h104);
        EX_flush = 1'b1;
        #1;
        chk("fl_force", 32'(ras_pred_valid), 32'd0);
        EX_flush = 1'b0;
        ID_valid = 1'b0;
        #1;
        chk("inv_force", 32'(ras_pred_valid), 32'd0);
        step();

        // stall holds state while predicting
        do_reset();
        push(32'h400);
        step();
        ret(32'h500);
        ID_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("st_valid", 32'(ras_pred_valid), 32'd1);
            chk("st_target", ras_pred_target, 32'h404);
            chk("st_ckpt", 32'(ras_ckpt), ck(1, 1));
            step();
        end
        ID_stall = 1'b0;
        settle();
        chk("st_rel", 32'(ras_ckpt), ck(0, 0));
        step();
        idle();
        settle();
        chk("st_empty", 32'(ras_empty), 32'd1);
        chk("st_once", 32'(ras_ckpt), ck(0, 0));
        step();

        // reset during a pending push discards it
        push(32'h600);
        #2;
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle();
        settle();
        chk("rp_ckpt", 32'(ras_ckpt), 32'd0);
        chk("rp_target", ras_pred_target, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
